// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the two-requester shifter arbiter.
// Imported by the arbiter top and by the shared shifter.
package shift_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic SH_LOGIC  = 1'b0;
  localparam logic SH_ARITH  = 1'b1;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        dir;
    logic        lora;
  } shift_op_t;

endpackage

// File: rtl/shift_arbiter_shift32.sv
// Generic 32-bit combinational shifter: logical left, logical right, arithmetic right.
// The lora select only matters for right shifts.
module shift_arbiter_shift32
  import shift_arbiter_pkg::*;
(
  input  logic [31:0] in,
  input  logic [4:0]  sh_amt,
  input  logic        direction,
  input  logic        lora,
  output logic [31:0] out
);

  always_comb begin
    if (direction == DIR_RIGHT && lora == SH_ARITH) begin
      out = $signed(in) >>> sh_amt;
    end else if (direction == DIR_RIGHT && lora == SH_LOGIC) begin
      out = in >> sh_amt;
    end else begin
      out = in << sh_amt;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one 32-bit shifter between two requesters: arbitrate, latch, shift for
// one cycle, then hold the registered result until the owner acknowledges it.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int RR_MODE = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [4:0]       req0_shamt,
  input  logic             req0_dir,
  input  logic             req0_lora,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_data,
  input  logic             rsp0_ack,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [4:0]       req1_shamt,
  input  logic             req1_dir,
  input  logic             req1_lora,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_data,
  input  logic             rsp1_ack,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        owner;
  shift_op_t   op;
  shift_op_t   req0_op, req1_op;
  logic [31:0] result;
  logic [31:0] shift_out;
  logic [1:0]  grant;
  logic        accept;
  logic        owner_ack;

  assign req0_op   = '{data: req0_data, shamt: req0_shamt, dir: req0_dir, lora: req0_lora};
  assign req1_op   = '{data: req1_data, shamt: req1_shamt, dir: req1_dir, lora: req1_lora};
  assign accept    = req0_ready | req1_ready;
  assign owner_ack = owner ? rsp1_ack : rsp0_ack;

  // On a tie, round-robin hands the grant to whoever did not win last time.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = 2'b00;
    case ({req1_valid, req0_valid})
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (RR_MODE != 0 && last_grant == 1'b0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (owner_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_data  = '0;
    busy       = (state != S_IDLE);
    if (state == S_IDLE) begin
      req0_ready = grant[0];
      req1_ready = grant[1];
    end
    if (state == S_RESP) begin
      if (owner) begin
        rsp1_valid = 1'b1;
        rsp1_data  = result;
      end else begin
        rsp0_valid = 1'b1;
        rsp0_data  = result;
      end
    end
  end

  // Operand latch, result register and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op         <= '0;
      result     <= '0;
      ops_done   <= '0;
    end else begin
      if (accept) begin
        op         <= grant[1] ? req1_op : req0_op;
        owner      <= grant[1];
        last_grant <= grant[1];
      end
      if (state == S_EXEC) result <= shift_out;
      if (state == S_RESP && owner_ack) ops_done <= ops_done + CNT_W'(1);
    end
  end

  shift_arbiter_shift32 u_shift (
    .in        (op.data),
    .sh_amt    (op.shamt),
    .direction (op.dir),
    .lora      (op.lora),
    .out       (shift_out)
  );

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench: a round-robin instance (CNT_W=4, to reach the wrap quickly) and a
// fixed-priority instance share the same stimulus; expected values are hand-computed.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_dir, req_lora, rsp_ack;
  logic [31:0] req_data [2];
  logic [4:0]  req_shamt [2];
  logic [1:0]  ready, rsp_valid, fp_ready, fp_rsp_valid;
  logic [31:0] rsp_data [2];
  logic [31:0] fp_rsp_data [2];
  logic        busy, fp_busy;
  logic [3:0]  ops_done;
  logic [15:0] fp_ops_done;
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_ops = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.RR_MODE(1), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(ready[0]), .req0_data(req_data[0]),
    .req0_shamt(req_shamt[0]), .req0_dir(req_dir[0]), .req0_lora(req_lora[0]),
    .rsp0_valid(rsp_valid[0]), .rsp0_data(rsp_data[0]), .rsp0_ack(rsp_ack[0]),
    .req1_valid(req_valid[1]), .req1_ready(ready[1]), .req1_data(req_data[1]),
    .req1_shamt(req_shamt[1]), .req1_dir(req_dir[1]), .req1_lora(req_lora[1]),
    .rsp1_valid(rsp_valid[1]), .rsp1_data(rsp_data[1]), .rsp1_ack(rsp_ack[1]),
    .busy(busy), .ops_done(ops_done)
  );

  shift_arbiter #(.RR_MODE(0), .CNT_W(16)) u_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(fp_ready[0]), .req0_data(req_data[0]),
    .req0_shamt(req_shamt[0]), .req0_dir(req_dir[0]), .req0_lora(req_lora[0]),
    .rsp0_valid(fp_rsp_valid[0]), .rsp0_data(fp_rsp_data[0]), .rsp0_ack(rsp_ack[0]),
    .req1_valid(req_valid[1]), .req1_ready(fp_ready[1]), .req1_data(req_data[1]),
    .req1_shamt(req_shamt[1]), .req1_dir(req_dir[1]), .req1_lora(req_lora[1]),
    .rsp1_valid(fp_rsp_valid[1]), .rsp1_data(fp_rsp_data[1]), .rsp1_ack(rsp_ack[1]),
    .busy(fp_busy), .ops_done(fp_ops_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Leaves the bench 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on requester k with its ack already high.
  task automatic do_op(input int k, input logic [31:0] data, input logic [4:0] shamt,
                       input logic dir, input logic lora, input logic [31:0] exp,
                       input string tag);
    req_data[k]  = data;
    req_shamt[k] = shamt;
    req_dir[k]   = dir;
    req_lora[k]  = lora;
    req_valid[k] = 1'b1;
    #1;
    for (int i = 0; i < 10 && ready[k] !== 1'b1; i++) begin
      step();
      #1;
    end
    check({tag, "_ready"}, 32'(ready[k]), 32'd1);
    step();
    req_valid[k] = 1'b0;
    #1;
    for (int i = 0; i < 10 && rsp_valid[k] !== 1'b1; i++) begin
      step();
      #1;
    end
    check({tag, "_rsp"}, rsp_data[k], exp);
    step();
    exp_ops = (exp_ops + 1) % 16;
    #1;
    check({tag, "_ops"}, 32'(ops_done), 32'(exp_ops));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_dir   = 2'b00;
    req_lora  = 2'b00;
    rsp_ack   = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_data[i]  = '0;
      req_shamt[i] = '0;
    end
    step();
    step();
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ops", 32'(ops_done), 32'd0);
    check("rst_rsp0_data", rsp_data[0], 32'd0);
    check("rst_rsp1_data", rsp_data[1], 32'd0);
    check("rst_fp_busy", 32'(fp_busy), 32'd0);
    check("rst_fp_rsp1_data", fp_rsp_data[1], 32'd0);
    reset = 1'b0;
    step();

    // Single arithmetic right shift: accept at cycle 1, response at cycle 3.
    req_data[0] = 32'h8000_00F0; req_shamt[0] = 5'd4; req_dir[0] = 1'b0; req_lora[0] = 1'b1;
    req_valid[0] = 1'b1;
    #1;
    check("single_ready", 32'(ready), 32'b01);
    step();
    req_valid[0] = 1'b0;
    #1;
    check("single_exec_busy", 32'(busy), 32'd1);
    check("single_exec_novalid", 32'(rsp_valid), 32'd0);
    step();
    #1;
    check("single_rsp_valid", 32'(rsp_valid), 32'b01);
    check("single_rsp_data", rsp_data[0], 32'hF800_000F);
    step();
    #1;
    check("single_ops", 32'(ops_done), 32'd1);
    check("single_done_valid", 32'(rsp_valid), 32'd0);
    check("single_done_busy", 32'(busy), 32'd0);
    exp_ops = 1;

    do_op(0, 32'h8000_00F0, 5'd4, 1'b0, 1'b0, 32'h0800_000F, "lsr");
    do_op(0, 32'h8000_00F0, 5'd4, 1'b1, 1'b0, 32'h0000_0F00, "lsl");
    do_op(0, 32'h8000_00F0, 5'd4, 1'b1, 1'b1, 32'h0000_0F00, "lsl_lora");

    // Contention: both valid throughout, both acking immediately.
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ops = 0;
    req_data[0] = 32'h0000_0001; req_shamt[0] = 5'd1; req_dir[0] = 1'b1; req_lora[0] = 1'b0;
    req_data[1] = 32'h0000_0010; req_shamt[1] = 5'd4; req_dir[1] = 1'b0; req_lora[1] = 1'b0;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
      check("rr_grant", 32'(ready), (g % 2 == 1) ? 32'b10 : 32'b01);
      check("fp_grant", 32'(fp_ready), 32'b01);
      step();
      #1;
      check("rr_exec_ready", 32'(ready), 32'd0);
      check("fp_exec_ready", 32'(fp_ready), 32'd0);
      step();
      #1;
      check("rr_rsp_owner", 32'(rsp_valid), (g % 2 == 1) ? 32'b10 : 32'b01);
      check("rr_rsp_data", rsp_data[g % 2], (g % 2 == 1) ? 32'h0000_0001 : 32'h0000_0002);
      check("fp_rsp_owner", 32'(fp_rsp_valid), 32'b01);
      check("fp_rsp_data", fp_rsp_data[0], 32'h0000_0002);
      step();
      exp_ops++;
    end
    req_valid = 2'b00;
    #1;
    check("rr_ops", 32'(ops_done), 32'(exp_ops));

    // Back-pressure: owner ack withheld while requester 1 waits; stray ack on requester 1.
    rsp_ack = 2'b10;
    req_data[0] = 32'h1234_5678; req_shamt[0] = 5'd8; req_dir[0] = 1'b0; req_lora[0] = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    check("bp_ready0", 32'(ready), 32'b01);
    step();
    req_valid[0] = 1'b0;
    req_data[1] = 32'hFFFF_0000; req_shamt[1] = 5'd16; req_dir[1] = 1'b0; req_lora[1] = 1'b1;
    req_valid[1] = 1'b1;
    #1;
    check("bp_exec_ready", 32'(ready), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_valid", 32'(rsp_valid), 32'b01);
      check("bp_hold_data", rsp_data[0], 32'h0012_3456);
      check("bp_hold_ready1", 32'(ready), 32'd0);
      check("bp_hold_busy", 32'(busy), 32'd1);
      step();
    end
    rsp_ack = 2'b11;
    #1;
    check("bp_ack_valid", 32'(rsp_valid), 32'b01);
    step();
    #1;
    exp_ops++;
    check("bp_ready1", 32'(ready), 32'b10);
    check("bp_ops", 32'(ops_done), 32'(exp_ops));
    step();
    req_valid[1] = 1'b0;
    step();
    #1;
    check("bp_rsp1_valid", 32'(rsp_valid), 32'b10);
    check("bp_rsp1_data", rsp_data[1], 32'hFFFF_FFFF);
    step();
    exp_ops++;
    #1;
    check("bp_ops2", 32'(ops_done), 32'(exp_ops));

    // Reset while the operation is in EXEC.
    req_data[0] = 32'hDEAD_BEEF; req_shamt[0] = 5'd4; req_dir[0] = 1'b1; req_lora[0] = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    check("rst_mid_ready", 32'(ready), 32'b01);
    step();
    req_valid[0] = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_ops", 32'(ops_done), 32'd0);
    check("rst_mid_idle", 32'(busy), 32'd0);
    check("rst_mid_fp_ops", 32'(fp_ops_done), 32'd0);
    step();
    #1;
    check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    step();
    exp_ops = 0;

    do_op(0, 32'hA5A5_5A5A, 5'd0, 1'b0, 1'b1, 32'hA5A5_5A5A, "sh0_asr");
    do_op(1, 32'h8765_4321, 5'd0, 1'b1, 1'b0, 32'h8765_4321, "sh0_lsl");

    // Run the 4-bit counter up to 15, then one more completion wraps it to 0.
    for (int i = 0; exp_ops != 15; i++) begin
      do_op(0, 32'(i + 3), 5'd1, 1'b1, 1'b0, 32'((i + 3) * 2), "fill");
    end
    do_op(1, 32'h0000_0100, 5'd8, 1'b0, 1'b0, 32'h0000_0001, "wrap");
    check("wrap_zero", 32'(ops_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
